// File: rtl/rocket_core_seq_pkg.sv
// Shared state encoding and timeout defaults for the core sequencer.
package rocket_core_seq_pkg;

    localparam int unsigned TIMEOUT_W_DEF      = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1000;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_STARTING = 3'd1,
        ST_RUN      = 3'd2,
        ST_HALTING  = 3'd3,
        ST_STOPPING = 3'd4
    } state_e;

    function automatic logic core_en_of(input state_e s);
        return (s == ST_STARTING) || (s == ST_RUN) || (s == ST_HALTING);
    endfunction

    function automatic logic busy_of(input state_e s);
        return (s == ST_STARTING) || (s == ST_HALTING) || (s == ST_STOPPING);
    endfunction

endpackage

// File: rtl/rocket_core_seq_util_sync.sv
// util_sync: two-flop synchronizer with configurable reset value.
module util_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ff_q <= {2{RESET_VAL}};
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/rocket_core_seq.sv
// Core power-up/halt/stop sequencer with registered outputs.
// Define ROCKET_CORE_SEQ_TIMEOUT_EN to enable the halt-acknowledge timeout.
module rocket_core_seq
    import rocket_core_seq_pkg::*;
#(
    parameter int unsigned          TIMEOUT_W      = TIMEOUT_W_DEF,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_W'(TIMEOUT_CYCLES_DEF)
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic start_i,
    input  logic stop_i,
    output logic core_en_o,
    input  logic core_reset_n_i,
    output logic core_halt_req_o,
    input  logic core_halted_i,
    output logic running_o,
    output logic busy_o,
    output logic timeout_o
);

    state_e state_q, state_d;
    logic   core_en_q, halt_req_q, running_q, busy_q;
    logic   timeout_q, timeout_d;
    logic   core_rst_sync, core_hlt_sync;

    util_sync #(.RESET_VAL(1'b0)) u_sync_rst (
        .clk_i  (clk_i),
        .rst_ni (reset_n_i),
        .d_i    (core_reset_n_i),
        .q_o    (core_rst_sync)
    );

    util_sync #(.RESET_VAL(1'b0)) u_sync_hlt (
        .clk_i  (clk_i),
        .rst_ni (reset_n_i),
        .d_i    (core_halted_i),
        .q_o    (core_hlt_sync)
    );

`ifdef ROCKET_CORE_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 expired;

    assign expired = (cnt_q == TIMEOUT_CYCLES - TIMEOUT_W'(1));

    // Counter idles at zero outside HALTING, so entry always starts from 0.
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_HALTING) begin
            cnt_d = cnt_q;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
            end
        end
    end
`else
    logic expired;
    logic unused_cfg;

    assign expired    = 1'b0;
    assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ST_OFF: begin
                if (start_i) begin
                    state_d   = ST_STARTING;
                    timeout_d = 1'b0;
                end
            end
            ST_STARTING: begin
                if (stop_i) begin
                    state_d = ST_STOPPING;
                end else if (core_rst_sync) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_HALTING;
                end
            end
            ST_HALTING: begin
                if (core_hlt_sync) begin
                    state_d = ST_STOPPING;
                end else if (expired) begin
                    state_d   = ST_STOPPING;
                    timeout_d = 1'b1;
                end
            end
            ST_STOPPING: begin
                if (!core_rst_sync) begin
                    state_d = ST_OFF;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Outputs are decoded from the next state so they land with the transition.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_OFF;
            core_en_q  <= 1'b0;
            halt_req_q <= 1'b0;
            running_q  <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef ROCKET_CORE_SEQ_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            core_en_q  <= core_en_of(state_d);
            halt_req_q <= (state_d == ST_HALTING);
            running_q  <= (state_d == ST_RUN);
            busy_q     <= busy_of(state_d);
            timeout_q  <= timeout_d;
`ifdef ROCKET_CORE_SEQ_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign core_en_o       = core_en_q;
    assign core_halt_req_o = halt_req_q;
    assign running_o       = running_q;
    assign busy_o          = busy_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_rocket_core_seq.sv
// Randomized bench for rocket_core_seq with a cycle-level reference model.
module tb_rocket_core_seq;

    localparam int TC = 8;
`ifdef ROCKET_CORE_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int M_OFF = 0, M_STARTING = 1, M_RUN = 2, M_HALTING = 3, M_STOPPING = 4;

    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;
    logic start_i = 1'b0;
    logic stop_i = 1'b0;
    logic core_reset_n_i;
    logic core_halted_i;
    logic core_en_o, core_halt_req_o, running_o, busy_o, timeout_o;

    int n_chk = 0;
    int n_fail = 0;

    int rel_dly = 8;
    int asrt_dly = 2;
    int halt_dly = 2;
    int c_cnt = 0;
    int h_cnt = 0;

    always #5 clk_i = ~clk_i;

    rocket_core_seq #(
        .TIMEOUT_W      (16),
        .TIMEOUT_CYCLES (16'd8)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .start_i         (start_i),
        .stop_i          (stop_i),
        .core_en_o       (core_en_o),
        .core_reset_n_i  (core_reset_n_i),
        .core_halt_req_o (core_halt_req_o),
        .core_halted_i   (core_halted_i),
        .running_o       (running_o),
        .busy_o          (busy_o),
        .timeout_o       (timeout_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] dut_vec();
        return {core_en_o, core_halt_req_o, running_o, busy_o, timeout_o};
    endfunction

    // Reference model: state advanced once per clock from the rules.
    int m_st = M_OFF;
    bit m_tmo = 1'b0;
    int m_hcyc = 0;
    bit rst_hist[$] = '{1'b0, 1'b0};
    bit hlt_hist[$] = '{1'b0, 1'b0};
    bit rs, hs;

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            m_st = M_OFF;
            m_tmo = 1'b0;
            m_hcyc = 0;
            rst_hist = '{1'b0, 1'b0};
            hlt_hist = '{1'b0, 1'b0};
        end else begin
            rs = rst_hist[1];
            hs = hlt_hist[1];
            rst_hist.push_front(core_reset_n_i);
            void'(rst_hist.pop_back());
            hlt_hist.push_front(core_halted_i);
            void'(hlt_hist.pop_back());
            case (m_st)
                M_OFF: if (start_i) begin
                    m_st = M_STARTING;
                    m_tmo = 1'b0;
                end
                M_STARTING: begin
                    if (stop_i) m_st = M_STOPPING;
                    else if (rs) m_st = M_RUN;
                end
                M_RUN: if (stop_i) begin
                    m_st = M_HALTING;
                    m_hcyc = 0;
                end
                M_HALTING: begin
                    m_hcyc++;
                    if (hs) m_st = M_STOPPING;
                    else if (TMO_EN && m_hcyc == TC) begin
                        m_st = M_STOPPING;
                        m_tmo = 1'b1;
                    end
                end
                M_STOPPING: if (!rs) m_st = M_OFF;
                default: m_st = M_OFF;
            endcase
        end
    end

    function automatic logic [4:0] exp_vec();
        logic en, hr, rn, bz;
        en = (m_st == M_STARTING) || (m_st == M_RUN) || (m_st == M_HALTING);
        hr = (m_st == M_HALTING);
        rn = (m_st == M_RUN);
        bz = (m_st == M_STARTING) || (m_st == M_HALTING) || (m_st == M_STOPPING);
        return {en, hr, rn, bz, m_tmo};
    endfunction

    always @(negedge clk_i) begin
        chk("model_outputs", {27'd0, dut_vec()}, {27'd0, exp_vec()});
    end

    // Core clock/reset controller and core halt behaviour.
    initial begin
        core_reset_n_i = 1'b0;
        core_halted_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (core_en_o != core_reset_n_i) begin
                if (c_cnt >= (core_en_o ? rel_dly : asrt_dly)) begin
                    core_reset_n_i = core_en_o;
                    c_cnt = 0;
                end else begin
                    c_cnt++;
                end
            end else begin
                c_cnt = 0;
            end
            if (!core_reset_n_i) begin
                core_halted_i = 1'b0;
                h_cnt = 0;
            end else if (core_halt_req_o && !core_halted_i) begin
                if (h_cnt >= halt_dly) core_halted_i = 1'b1;
                else h_cnt++;
            end else begin
                h_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input bit s, input bit p);
        start_i = s;
        stop_i = p;
        tick();
        start_i = 1'b0;
        stop_i = 1'b0;
    endtask

    // what: 0 = running, 1 = off and idle
    task automatic wait_for(input int what, input int lim, input string nm, output int n);
        bit ok;
        ok = 1'b0;
        n = 0;
        while (n < lim && !ok) begin
            if (what == 0) ok = running_o;
            else ok = !core_en_o && !busy_o;
            if (!ok) begin
                tick();
                n++;
            end
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    int n;
    int lat;
    bit busy_ok;
    bit saw;

    initial begin
        repeat (3) tick();
        reset_n_i = 1'b1;
        repeat (50) tick();
        chk("idle_outputs", {27'd0, dut_vec()}, 32'd0);

        // Start with controller releasing core reset 9 cycles later.
        rel_dly = 8;
        pulse(1'b1, 1'b0);
        chk("start_core_en", {31'd0, core_en_o}, 32'd1);
        lat = 1;
        busy_ok = 1'b1;
        while (!running_o && lat < 20) begin
            busy_ok &= busy_o;
            tick();
            lat++;
        end
        chk("start_latency", lat, 12);
        chk("busy_while_starting", {31'd0, busy_ok}, 32'd1);

        // Graceful halt acknowledged by the core.
        halt_dly = 2;
        pulse(1'b0, 1'b1);
        chk("halt_req_set", {31'd0, core_halt_req_o}, 32'd1);
        wait_for(1, 60, "halt_reaches_off", n);
        chk("halt_req_cleared", {31'd0, core_halt_req_o}, 32'd0);
        chk("no_timeout", {31'd0, timeout_o}, 32'd0);

        // Halt never acknowledged.
        rel_dly = 2;
        pulse(1'b1, 1'b0);
        wait_for(0, 30, "run_for_timeout", n);
        halt_dly = 100000;
        pulse(1'b0, 1'b1);
        n = 0;
        while (core_halt_req_o && n < 40) begin
            tick();
            n++;
        end
        if (TMO_EN) begin
            chk("halting_cycles", n, TC);
            chk("timeout_set", {31'd0, timeout_o}, 32'd1);
            chk("timeout_core_en", {31'd0, core_en_o}, 32'd0);
            wait_for(1, 40, "timeout_reaches_off", n);
            pulse(1'b1, 1'b0);
            chk("timeout_cleared", {31'd0, timeout_o}, 32'd0);
            wait_for(0, 30, "run_after_timeout", n);
            halt_dly = 1;
            pulse(1'b0, 1'b1);
        end else begin
            chk("halt_waits", {31'd0, core_halt_req_o}, 32'd1);
            chk("timeout_tied_low", {31'd0, timeout_o}, 32'd0);
            halt_dly = 0;
        end
        wait_for(1, 40, "back_to_off", n);

        // Same-cycle requests: start wins in OFF, stop wins in RUN.
        pulse(1'b1, 1'b1);
        chk("both_in_off", {30'd0, busy_o, running_o}, 32'd2);
        wait_for(0, 30, "run_again", n);
        halt_dly = 1;
        pulse(1'b1, 1'b1);
        chk("both_in_run", {31'd0, core_halt_req_o}, 32'd1);
        wait_for(1, 40, "both_reaches_off", n);

        // Stop while STARTING skips the halt phase.
        rel_dly = 20;
        pulse(1'b1, 1'b0);
        tick();
        tick();
        pulse(1'b0, 1'b1);
        chk("stop_in_starting", {30'd0, core_en_o, busy_o}, 32'd1);
        saw = core_halt_req_o;
        n = 0;
        while ((core_en_o || busy_o) && n < 20) begin
            tick();
            saw |= core_halt_req_o;
            n++;
        end
        chk("no_halt_req_from_starting", {31'd0, saw}, 32'd0);

        // Asynchronous reset in the middle of HALTING.
        rel_dly = 2;
        pulse(1'b1, 1'b0);
        wait_for(0, 30, "run_before_reset", n);
        halt_dly = 100000;
        pulse(1'b0, 1'b1);
        tick();
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("async_reset_outputs", {27'd0, dut_vec()}, 32'd0);
        tick();
        reset_n_i = 1'b1;
        tick();
        chk("off_after_reset", {27'd0, dut_vec()}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) begin
                rel_dly = $urandom_range(0, 12);
                asrt_dly = $urandom_range(0, 6);
                halt_dly = ($urandom % 2) ? $urandom_range(0, 2) : $urandom_range(10, 40);
            end
            start_i = ($urandom % 6) == 0;
            stop_i = ($urandom % 10) == 0;
            if (($urandom % 300) == 0) reset_n_i = 1'b0;
            tick();
            reset_n_i = 1'b1;
        end
        start_i = 1'b0;
        stop_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
